// File: rtl/dice_game_pkg.sv
// Shared types and constants for the craps-style dice game controller.
package dice_game_pkg;

    localparam int unsigned DEF_SUM_W  = 4;
    localparam int unsigned SUM_SEVEN  = 7;
    localparam int unsigned SUM_ELEVEN = 11;
    localparam int unsigned SUM_MIN    = 2;
    localparam int unsigned SUM_MAX    = 12;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ROLL1      = 3'd1,
        POINT_WAIT = 3'd2,
        ROLL2      = 3'd3,
        WIN        = 3'd4,
        LOSE       = 3'd5
    } state_t;

    // Craps set {2, 3, 12}: an immediate loss on the come-out roll.
    function automatic logic is_craps_sum(input int unsigned s);
        return (s == 2) || (s == 3) || (s == 12);
    endfunction

endpackage

// File: rtl/dice_sum_classify.sv
// Combinational classification of a dice sum against the game rules and the latched point.
module dice_sum_classify
    import dice_game_pkg::*;
#(
    parameter int unsigned SUM_W = DEF_SUM_W
) (
    input  logic [SUM_W-1:0] sum,
    input  logic [SUM_W-1:0] point,
    output logic             is_natural,
    output logic             is_craps,
    output logic             is_seven,
    output logic             is_point_match,
    output logic             is_legal
);

    assign is_seven       = (sum == SUM_W'(SUM_SEVEN));
    assign is_natural     = is_seven || (sum == SUM_W'(SUM_ELEVEN));
    assign is_craps       = is_craps_sum(32'(sum));
    assign is_point_match = (sum == point);
    assign is_legal       = (sum >= SUM_W'(SUM_MIN)) && (sum <= SUM_W'(SUM_MAX));

endmodule

// File: rtl/dice_game.sv
// Craps game sequencer: tracks come-out and point rolls, latches the point,
// and holds a sticky win/lose result until reset.
module dice_game
    import dice_game_pkg::*;
#(
    parameter int unsigned SUM_W = DEF_SUM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rb,
    input  logic [SUM_W-1:0] sum,
    output logic             roll,
    output logic             win,
    output logic             lose
);

    state_t           state;
    logic [SUM_W-1:0] point;
    logic             is_natural;
    logic             is_craps;
    logic             is_seven;
    logic             is_point_match;
    logic             is_legal;

    dice_sum_classify #(.SUM_W(SUM_W)) u_classify (
        .sum            (sum),
        .point          (point),
        .is_natural     (is_natural),
        .is_craps       (is_craps),
        .is_seven       (is_seven),
        .is_point_match (is_point_match),
        .is_legal       (is_legal)
    );

    // Outputs are registered alongside the state so they always mirror it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            point <= '0;
            roll  <= 1'b0;
            win   <= 1'b0;
            lose  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rb) begin
                        state <= ROLL1;
                        roll  <= 1'b1;
                    end
                end
                ROLL1: begin
                    if (!rb) begin
                        roll <= 1'b0;
                        if (is_natural) begin
                            state <= WIN;
                            win   <= 1'b1;
                        end else if (is_craps) begin
                            state <= LOSE;
                            lose  <= 1'b1;
                        end else if (is_legal) begin
                            state <= POINT_WAIT;
                            point <= sum;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                POINT_WAIT: begin
                    if (rb) begin
                        state <= ROLL2;
                        roll  <= 1'b1;
                    end
                end
                ROLL2: begin
                    if (!rb) begin
                        roll <= 1'b0;
                        // Point match takes priority over seven.
                        if (is_point_match) begin
                            state <= WIN;
                            win   <= 1'b1;
                        end else if (is_seven) begin
                            state <= LOSE;
                            lose  <= 1'b1;
                        end else begin
                            state <= POINT_WAIT;
                        end
                    end
                end
                WIN, LOSE: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                    roll  <= 1'b0;
                    win   <= 1'b0;
                    lose  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_game.sv
// Self-checking bench for dice_game: game-level reference model plus directed scenarios.
module tb_dice_game;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rb = 1'b0;
    logic [3:0] sum = 4'd0;
    logic       roll;
    logic       win;
    logic       lose;

    int tests  = 0;
    int failed = 0;
    bit started = 1'b0;

    // Game-level model: "rolling" flag, point (0 = come-out roll pending), result flags.
    logic m_rolling = 1'b0;
    logic m_win     = 1'b0;
    logic m_lose    = 1'b0;
    int   m_point   = 0;

    dice_game dut (
        .clk   (clk),
        .reset (reset),
        .rb    (rb),
        .sum   (sum),
        .roll  (roll),
        .win   (win),
        .lose  (lose)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int s;
        s = int'(sum);
        if (reset) begin
            m_rolling = 1'b0;
            m_win     = 1'b0;
            m_lose    = 1'b0;
            m_point   = 0;
            started   = 1'b1;
        end else if (m_win || m_lose) begin
            m_rolling = m_rolling;
        end else if (!m_rolling) begin
            if (rb) m_rolling = 1'b1;
        end else if (!rb) begin
            m_rolling = 1'b0;
            if (m_point == 0) begin
                if (s == 7 || s == 11)                 m_win   = 1'b1;
                else if (s == 2 || s == 3 || s == 12)  m_lose  = 1'b1;
                else if (s >= 4 && s <= 10)            m_point = s;
            end else begin
                if (s == m_point)  m_win  = 1'b1;
                else if (s == 7)   m_lose = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_roll", roll, m_rolling);
            chk("model_win",  win,  m_win);
            chk("model_lose", lose, m_lose);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rb    = 1'b0;
        cyc(1);
        reset = 1'b0;
        chk("rst_roll", roll, 1'b0);
        chk("rst_win",  win,  1'b0);
        chk("rst_lose", lose, 1'b0);
    endtask

    // One press of rb for a cycle, then release with the dice total.
    task automatic do_roll(input logic [3:0] s);
        rb = 1'b1;
        cyc(1);
        chk("rolling", roll, 1'b1);
        rb  = 1'b0;
        sum = s;
        cyc(1);
        chk("roll_done", roll, 1'b0);
    endtask

    initial begin
        cyc(1);
        do_reset();

        // 1: natural seven on come-out
        do_roll(4'd7);
        chk("t1_win", win, 1'b1);
        chk("t1_lose", lose, 1'b0);
        cyc(3);
        chk("t1_win_sticky", win, 1'b1);

        // 2: craps three, later presses ignored
        do_reset();
        do_roll(4'd3);
        chk("t2_lose", lose, 1'b1);
        chk("t2_win", win, 1'b0);
        rb = 1'b1; cyc(2); rb = 1'b0; cyc(1);
        chk("t2_lose_sticky", lose, 1'b1);
        chk("t2_no_roll", roll, 1'b0);

        // 3: point 4 then make the point
        do_reset();
        do_roll(4'd4);
        chk("t3_nowin", win, 1'b0);
        chk("t3_nolose", lose, 1'b0);
        do_roll(4'd4);
        chk("t3_win", win, 1'b1);

        // 4: craps twelve; then point 6 sevens out
        do_reset();
        do_roll(4'd12);
        chk("t4_lose12", lose, 1'b1);
        do_reset();
        do_roll(4'd6);
        do_roll(4'd7);
        chk("t4_sevenout", lose, 1'b1);
        chk("t4_sevenout_win", win, 1'b0);

        // 5: point 5, non-deciding rolls incl. illegal 13, then hit 5
        do_reset();
        do_roll(4'd5);
        do_roll(4'd8);
        do_roll(4'd9);
        do_roll(4'd13);
        chk("t5_pending_win", win, 1'b0);
        chk("t5_pending_lose", lose, 1'b0);
        do_roll(4'd5);
        chk("t5_win", win, 1'b1);

        // 6a: reset mid-roll in the point phase
        do_reset();
        do_roll(4'd8);
        rb = 1'b1;
        cyc(2);
        chk("t6_roll2", roll, 1'b1);
        reset = 1'b1;
        cyc(1);
        chk("t6_rst_roll", roll, 1'b0);
        reset = 1'b0;
        rb    = 1'b0;
        cyc(1);
        chk("t6_idle_roll", roll, 1'b0);
        // point was cleared: seven now wins as a come-out roll
        do_roll(4'd7);
        chk("t6_comeout_win", win, 1'b1);
        // 6b: reset while winning
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_rst_win", win, 1'b0);

        // 6c: illegal come-out sum returns to the come-out roll
        do_roll(4'd0);
        chk("t6_ill_win", win, 1'b0);
        chk("t6_ill_lose", lose, 1'b0);
        do_roll(4'd11);
        chk("t6_after_ill_win", win, 1'b1);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
